uart_sniff_arb: RTL and testbench

Traffic tap that feeds the PC-facing UART transmitter of the man-in-the-middle design. It captures every byte received from board 1 and board 2 (`valid`/`data` outputs of their `uart_rx` instances), buffers each stream in its own FIFO, and forwards them to the PC. Each byte is sent as a two-byte record: a source tag, then the data. It arbitrates fairly between the two streams and drives the `en`/`data_in`/`rdy` handshake of a `uart_tx`.

---
 rtl/uart_sniff_arb_pkg.sv | 30 +++
 rtl/uart_sniff_arb_sniff_fifo.sv | 48 ++++
 rtl/uart_sniff_arb.sv | 133 +++++++++++++
 tb/tb_uart_sniff_arb.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sniff_arb_pkg.sv
// Shared definitions for the UART sniffer tap: tag defaults, FSM states and
// the round-robin source picker.
package uart_sniff_arb_pkg;

  localparam int unsigned FIFO_DEPTH_DEF = 16;
  localparam logic [7:0]  TAG_B1_DEF     = 8'h31;
  localparam logic [7:0]  TAG_B2_DEF     = 8'h32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TAG_WAIT,
    ST_TAG_RDY,
    ST_DATA_WAIT,
    ST_DATA_RDY
  } state_t;

  typedef enum logic {
    SRC_B1 = 1'b0,
    SRC_B2 = 1'b1
  } src_t;

  // On a tie the source not served last time wins.
  function automatic src_t rr_pick(input logic b1_ne, input logic b2_ne,
                                   input src_t last);
    if (b1_ne && b2_ne) return (last == SRC_B2) ? SRC_B1 : SRC_B2;
    else if (b1_ne)     return SRC_B1;
    else                return SRC_B2;
  endfunction

endpackage

// File: rtl/uart_sniff_arb_sniff_fifo.sv
// Synchronous first-word-fall-through byte FIFO with wrap-bit pointers.
// A read in the same cycle as a write frees a slot, so a full FIFO accepts it.
module sniff_fifo
  import uart_sniff_arb_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_wr;
  logic        do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_sniff_arb.sv
// Traffic tap: buffers board-1/board-2 received bytes and forwards them to
// the PC uart_tx as atomic {tag, data} records with round-robin arbitration.
module uart_sniff_arb
  import uart_sniff_arb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter logic [7:0]  TAG_B1     = TAG_B1_DEF,
  parameter logic [7:0]  TAG_B2     = TAG_B2_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sniff_en,
  input  logic       b1_valid,
  input  logic [7:0] b1_data,
  input  logic       b2_valid,
  input  logic [7:0] b2_data,
  input  logic       tx_rdy,
  output logic       tx_en,
  output logic [7:0] tx_data,
  output logic [7:0] b1_drops,
  output logic [7:0] b2_drops
);

  logic [1:0] rst_sync;
  logic       rst_n;

  // Assertion is immediate; release is retimed to clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= '0;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic       b1_wr, b2_wr;
  logic       b1_pop, b2_pop;
  logic       b1_full, b2_full;
  logic       b1_empty, b2_empty;
  logic [7:0] b1_head, b2_head;
  logic       b1_drop, b2_drop;

  assign b1_wr = sniff_en && b1_valid;
  assign b2_wr = sniff_en && b2_valid;

  sniff_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (b1_wr),
    .wr_data (b1_data),
    .rd_en   (b1_pop),
    .rd_data (b1_head),
    .full    (b1_full),
    .empty   (b1_empty)
  );

  sniff_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (b2_wr),
    .wr_data (b2_data),
    .rd_en   (b2_pop),
    .rd_data (b2_head),
    .full    (b2_full),
    .empty   (b2_empty)
  );

  assign b1_drop = b1_wr && b1_full && !b1_pop;
  assign b2_drop = b2_wr && b2_full && !b2_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b1_drops <= '0;
      b2_drops <= '0;
    end else begin
      if (b1_drop && (b1_drops != '1)) b1_drops <= b1_drops + 8'd1;
      if (b2_drop && (b2_drops != '1)) b2_drops <= b2_drops + 8'd1;
    end
  end

  state_t     state_q, state_d;
  src_t       last_q, sel;
  logic [7:0] hold_q;
  logic       hold_ld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= SRC_B2;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (hold_ld) begin
        last_q <= sel;
        hold_q <= (sel == SRC_B1) ? b1_head : b2_head;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    tx_en   = 1'b0;
    tx_data = '0;
    b1_pop  = 1'b0;
    b2_pop  = 1'b0;
    hold_ld = 1'b0;
    sel     = rr_pick(!b1_empty, !b2_empty, last_q);
    unique case (state_q)
      ST_IDLE: begin
        if ((!b1_empty || !b2_empty) && tx_rdy) begin
          tx_en   = 1'b1;
          tx_data = (sel == SRC_B1) ? TAG_B1 : TAG_B2;
          b1_pop  = (sel == SRC_B1);
          b2_pop  = (sel == SRC_B2);
          hold_ld = 1'b1;
          state_d = ST_TAG_WAIT;
        end
      end
      ST_TAG_WAIT: state_d = ST_TAG_RDY;
      ST_TAG_RDY: begin
        if (tx_rdy) begin
          tx_en   = 1'b1;
          tx_data = hold_q;
          state_d = ST_DATA_WAIT;
        end
      end
      ST_DATA_WAIT: state_d = ST_DATA_RDY;
      ST_DATA_RDY: begin
        if (tx_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_sniff_arb.sv
// Scoreboard bench for uart_sniff_arb: expected tx bytes are queued by the
// stimulus and popped by a monitor on every tx_en strobe.
module tb_uart_sniff_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sniff_en = 1'b0;
  logic       b1_valid = 1'b0;
  logic [7:0] b1_data = '0;
  logic       b2_valid = 1'b0;
  logic [7:0] b2_data = '0;
  logic       tx_rdy;
  logic       tx_en;
  logic [7:0] tx_data;
  logic [7:0] b1_drops;
  logic [7:0] b2_drops;

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [7:0]  exp_q [$];

  always #5 clk = ~clk;

  uart_sniff_arb #(.FIFO_DEPTH(16), .TAG_B1(8'h31), .TAG_B2(8'h32)) dut (
    .clk      (clk),
    .rst      (rst),
    .sniff_en (sniff_en),
    .b1_valid (b1_valid),
    .b1_data  (b1_data),
    .b2_valid (b2_valid),
    .b2_data  (b2_data),
    .tx_rdy   (tx_rdy),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .b1_drops (b1_drops),
    .b2_drops (b2_drops)
  );

  // uart_tx model: busy for 10 cycles after each accepted en.
  logic [3:0] busy = '0;
  logic       rdy_gate = 1'b1;
  assign tx_rdy = rdy_gate && (busy == 4'd0);

  always @(posedge clk) begin
    if (tx_en)            busy <= 4'd10;
    else if (busy != 4'd0) busy <= busy - 4'd1;
  end

  logic       prev_en = 1'b0;
  logic [7:0] exp_b;

  always @(negedge clk) begin
    if (tx_en) begin
      checks++;
      if (!tx_rdy || prev_en) begin
        failures++;
        $display("FAIL tx_en_protocol: tx_rdy=%0b prev_en=%0b, required tx_rdy=1 prev_en=0",
                 tx_rdy, prev_en);
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_tx: got %02h, required no transmission", tx_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (tx_data !== exp_b) begin
          failures++;
          $display("FAIL tx_byte: got %02h, required %02h", tx_data, exp_b);
        end
      end
    end
    prev_en <= tx_en;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h, required %02h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic v1, input logic [7:0] d1,
                        input logic v2, input logic [7:0] d2);
    @(posedge clk); #1;
    b1_valid = v1; b1_data = d1;
    b2_valid = v2; b2_data = d2;
    @(posedge clk); #1;
    b1_valid = 1'b0; b2_valid = 1'b0;
  endtask

  task automatic push_rec(input logic [7:0] tag, input logic [7:0] d);
    exp_q.push_back(tag);
    exp_q.push_back(d);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: %0d bytes pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
    cycles(30);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b0;
    cycles(3);
    rst = 1'b1;
    cycles(4);
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    chk("reset_tx_en", {7'd0, tx_en}, 8'h00);
    chk("reset_tx_data", tx_data, 8'h00);
    chk("reset_b1_drops", b1_drops, 8'h00);
    chk("reset_b2_drops", b2_drops, 8'h00);
    cycles(3);
    rst = 1'b1;
    sniff_en = 1'b1;
    cycles(4);

    // single byte
    push_rec(8'h31, 8'hA5);
    strobe(1'b1, 8'hA5, 1'b0, 8'h00);
    wait_drain("single");

    // simultaneous: fresh reset so B1 wins the first tie
    do_reset();
    push_rec(8'h31, 8'h11);
    push_rec(8'h32, 8'h22);
    strobe(1'b1, 8'h11, 1'b1, 8'h22);
    wait_drain("simul");

    // three bytes each; last served was B2, so B1 leads
    for (int i = 0; i < 3; i++) begin
      push_rec(8'h31, 8'hA0 + 8'(i));
      push_rec(8'h32, 8'hB0 + 8'(i));
    end
    for (int i = 0; i < 3; i++) strobe(1'b1, 8'hA0 + 8'(i), 1'b1, 8'hB0 + 8'(i));
    wait_drain("alternate");

    // overflow on b1 with tx stalled
    rdy_gate = 1'b0;
    for (int i = 0; i < 20; i++) strobe(1'b1, 8'(i), 1'b0, 8'h00);
    cycles(2);
    chk("overflow_b1_drops", b1_drops, 8'd4);
    for (int i = 0; i < 16; i++) push_rec(8'h31, 8'(i));
    rdy_gate = 1'b1;
    wait_drain("overflow");

    // b2 saturation: 16 kept, 300 dropped
    rdy_gate = 1'b0;
    for (int i = 0; i < 316; i++) strobe(1'b0, 8'h00, 1'b1, 8'(i));
    cycles(2);
    chk("sat_b2_drops", b2_drops, 8'd255);
    strobe(1'b0, 8'h00, 1'b1, 8'hEE);
    cycles(2);
    chk("sat_b2_hold", b2_drops, 8'd255);
    chk("sat_b1_unchanged", b1_drops, 8'd4);
    for (int i = 0; i < 16; i++) push_rec(8'h32, 8'(i));
    rdy_gate = 1'b1;
    wait_drain("saturate");

    // gating: ignored strobes, no drop counting
    sniff_en = 1'b0;
    for (int i = 0; i < 5; i++) strobe(1'b1, 8'hC0 + 8'(i), 1'b0, 8'h00);
    cycles(30);
    chk("gate_b1_drops", b1_drops, 8'd4);
    chk("gate_b2_drops", b2_drops, 8'd255);

    // sniff_en cleared between tag and data
    sniff_en = 1'b1;
    push_rec(8'h31, 8'h77);
    strobe(1'b1, 8'h77, 1'b0, 8'h00);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        if (tx_en) seen = 1'b1;
      end
      chk("midrec_tag_seen", {7'd0, seen}, 8'h01);
    end
    #1 sniff_en = 1'b0;
    strobe(1'b1, 8'h88, 1'b0, 8'h00);
    wait_drain("midrec");
    sniff_en = 1'b1;

    // reset asserted while in TAG_RDY with tx_rdy high
    exp_q.push_back(8'h31);
    strobe(1'b1, 8'h55, 1'b0, 8'h00);
    strobe(1'b1, 8'h66, 1'b0, 8'h00);
    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
      chk("rstmid_tag_sent", 8'(exp_q.size()), 8'h00);
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!tx_rdy && n < 100);
      chk("rstmid_data_pending_en", {7'd0, tx_en}, 8'h01);
      chk("rstmid_data_pending", tx_data, 8'h55);
      #1 rst = 1'b0;
      #1;
      chk("rstmid_tx_en", {7'd0, tx_en}, 8'h00);
      chk("rstmid_tx_data", tx_data, 8'h00);
      cycles(3);
      rst = 1'b1;
      cycles(5);
      chk("rstmid_b1_drops", b1_drops, 8'h00);
      chk("rstmid_b2_drops", b2_drops, 8'h00);
      cycles(30);
    end
    push_rec(8'h32, 8'h99);
    strobe(1'b0, 8'h00, 1'b1, 8'h99);
    wait_drain("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
